// File: rtl/flash_boot_loader.sv
// flash_boot_loader: copies LEN bytes from the SPI flash reader into RAM.
// Bytes are packed little-endian into DATA_W-bit words. Each word goes
// through a small FIFO and is written with full byte strobes on a
// valid/ready port. busy holds the softcore in reset until the copy is
// done, and reload re-runs the copy.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   ram_busy           RAM not initialised; the copy waits while high
//   reload             one-cycle pulse; restarts the copy from DONE
//   flash_start        one-cycle pulse that starts the flash reader
//   flash_dout/strb    flash byte and its valid strobe
//   mem_valid/ready    RAM write handshake
//   mem_addr           byte address of the word, BYTES-aligned
//   mem_wdata/wstrb    write word and byte strobes (all-ones while valid)
//   busy / done        copy in progress / copy complete (sticky)
//   checksum           modulo-2^32 sum of the bytes accepted while streaming
//   error              sticky flag: a word was dropped on FIFO overflow
module flash_boot_loader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned LEN        = 262144,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ram_busy,
  input  logic                  reload,
  output logic                  flash_start,
  input  logic [7:0]            flash_dout,
  input  logic                  flash_strb,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum,
  output logic                  error
);

  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BYTES);
  localparam int unsigned CNT_W  = $clog2(LEN + 1);
  localparam int unsigned IDX_W  = CNT_W - LANE_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    WAIT_RAM = 2'd0,
    STREAM   = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  // FIFO entry: the word index travels with the data, so a dropped word
  // leaves a hole in the address sequence instead of shifting later words.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t              state;
  state_t              state_next;
  logic                start_next;

  logic [CNT_W-1:0]    byte_cnt;
  logic [DATA_W-1:0]   pack;
  logic [LANE_W-1:0]   lane;
  logic [DATA_W-1:0]   word_c;
  logic                accept;
  logic                word_done;

  entry_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FILL_W-1:0]   fill;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  entry_t              head;
  logic [ADDR_W-1:0]   addr_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_RAM;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    case (state)
      WAIT_RAM: begin
        if (!ram_busy) begin
          state_next = STREAM;
          start_next = 1'b1;
        end
      end
      STREAM: begin
        if (accept && (byte_cnt == CNT_W'(LEN - 1))) state_next = DRAIN;
      end
      DRAIN: begin
        // Anticipate the last handshake so done rises on the following cycle
        if (fifo_empty && (!mem_valid || mem_ready)) state_next = DONE;
      end
      DONE: begin
        if (reload) state_next = WAIT_RAM;
      end
      default: state_next = WAIT_RAM;
    endcase
  end

  // Byte packer and FIFO control
  always_comb begin
    accept     = (state == STREAM) && flash_strb;
    lane       = byte_cnt[LANE_W-1:0];
    word_c     = pack;
    word_c[{lane, 3'b000} +: 8] = flash_dout;
    word_done  = accept && (lane == LANE_W'(BYTES - 1));
    fifo_empty = (fill == '0);
    fifo_full  = (fill == FILL_W'(FIFO_DEPTH));
    pop        = !fifo_empty && (!mem_valid || mem_ready);
    // A pop on the same edge frees a slot, so a full FIFO still accepts
    push       = word_done && (!fifo_full || pop);
    head       = fifo_mem[rd_ptr];
    addr_c     = ADDR_W'(BASE_ADDR) + ADDR_W'({head.idx, {LANE_W{1'b0}}});
  end

  // Status, counters and checksum
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      byte_cnt    <= '0;
      pack        <= '0;
      checksum    <= '0;
      error       <= 1'b0;
    end else begin
      flash_start <= start_next;
      busy        <= (state_next != DONE);
      done        <= (state_next == DONE);
      if ((state == DONE) && reload) begin
        byte_cnt <= '0;
        checksum <= '0;
        error    <= 1'b0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
        pack     <= word_c;
        checksum <= checksum + 32'(flash_dout);
        if (word_done && !push) error <= 1'b1;
      end
    end
  end

  // FIFO pointers and fill level
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{idx: byte_cnt[CNT_W-1:LANE_W], data: word_c};
  end

  // Write port output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (pop) begin
      mem_valid <= 1'b1;
      mem_addr  <= addr_c;
      mem_wdata <= head.data;
      mem_wstrb <= '1;
    end else if (mem_valid && mem_ready) begin
      mem_valid <= 1'b0;
      mem_wstrb <= '0;
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed bench for flash_boot_loader: three instances (32-bit, 64-bit at
// a non-zero base, and a 2-deep FIFO for overflow) share clock and flash
// inputs. Expected RAM writes are tables of records compared in loops.
module tb_flash_boot_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        rst_ov;
  logic        ram_busy;
  logic        reload;
  logic [7:0]  flash_dout;
  logic        flash_strb;
  logic        mem_ready;
  logic        ready_ov;

  logic        fs32, mv32, busy32, done32, err32;
  logic [22:0] ma32;
  logic [31:0] wd32, cs32;
  logic [3:0]  ws32;

  logic        fs64, mv64, busy64, done64, err64;
  logic [22:0] ma64;
  logic [63:0] wd64;
  logic [31:0] cs64;
  logic [7:0]  ws64;

  logic        fs_ov, mv_ov, busy_ov, done_ov, err_ov;
  logic [22:0] ma_ov;
  logic [31:0] wd_ov, cs_ov;
  logic [3:0]  ws_ov;

  int n_pass  = 0;
  int n_total = 0;

  wr_t q32[$];
  wr_t q64[$];
  wr_t qov[$];
  wr_t exp_basic[$];
  wr_t exp_64[$];
  wr_t exp_bp[$];
  wr_t exp_ov[$];

  flash_boot_loader #(.DATA_W(32), .ADDR_W(23), .BASE_ADDR(0), .LEN(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ram_busy(ram_busy), .reload(reload),
    .flash_start(fs32), .flash_dout(flash_dout), .flash_strb(flash_strb),
    .mem_valid(mv32), .mem_ready(mem_ready), .mem_addr(ma32), .mem_wdata(wd32),
    .mem_wstrb(ws32), .busy(busy32), .done(done32), .checksum(cs32), .error(err32));

  flash_boot_loader #(.DATA_W(64), .ADDR_W(23), .BASE_ADDR(32'h100), .LEN(16), .FIFO_DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .ram_busy(ram_busy), .reload(reload),
    .flash_start(fs64), .flash_dout(flash_dout), .flash_strb(flash_strb),
    .mem_valid(mv64), .mem_ready(mem_ready), .mem_addr(ma64), .mem_wdata(wd64),
    .mem_wstrb(ws64), .busy(busy64), .done(done64), .checksum(cs64), .error(err64));

  flash_boot_loader #(.DATA_W(32), .ADDR_W(23), .BASE_ADDR(0), .LEN(24), .FIFO_DEPTH(2)) dut_ov (
    .clk(clk), .reset(rst_ov), .ram_busy(ram_busy), .reload(reload),
    .flash_start(fs_ov), .flash_dout(flash_dout), .flash_strb(flash_strb),
    .mem_valid(mv_ov), .mem_ready(ready_ov), .mem_addr(ma_ov), .mem_wdata(wd_ov),
    .mem_wstrb(ws_ov), .busy(busy_ov), .done(done_ov), .checksum(cs_ov), .error(err_ov));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed handshake, sampled mid-cycle before the edge
  always @(negedge clk) begin
    if (mv32 && mem_ready) q32.push_back('{32'(ma32), 64'(wd32), 8'(ws32)});
    if (mv64 && mem_ready) q64.push_back('{32'(ma64), wd64, ws64});
    if (mv_ov && ready_ov) qov.push_back('{32'(ma_ov), 64'(wd_ov), 8'(ws_ov)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_writes(input string name, input wr_t got[$], input wr_t exp[$]);
    check({name, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), 64'(got[i].addr), 64'(exp[i].addr));
      check($sformatf("%s_data%0d", name, i), got[i].data, exp[i].data);
      check($sformatf("%s_strb%0d", name, i), 64'(got[i].strb), 64'(exp[i].strb));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    flash_dout = b;
    flash_strb = 1'b1;
    tick();
    flash_strb = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected the run to finish");
    $fatal(1);
  end

  initial begin
    logic        bad_start;
    logic        bad_busy;
    logic        bad_stall;
    logic [22:0] a0;
    logic [31:0] w0;
    int          c;

    exp_basic.push_back('{32'h0, 64'h0302_0100, 8'h0F});
    exp_basic.push_back('{32'h4, 64'h0706_0504, 8'h0F});
    exp_basic.push_back('{32'h8, 64'h0B0A_0908, 8'h0F});
    exp_basic.push_back('{32'hC, 64'h0F0E_0D0C, 8'h0F});
    exp_64.push_back('{32'h100, 64'h0706_0504_0302_0100, 8'hFF});
    exp_64.push_back('{32'h108, 64'h0F0E_0D0C_0B0A_0908, 8'hFF});
    exp_bp.push_back('{32'h0, 64'h1312_1110, 8'h0F});
    exp_bp.push_back('{32'h4, 64'h1716_1514, 8'h0F});
    exp_bp.push_back('{32'h8, 64'h1B1A_1918, 8'h0F});
    exp_bp.push_back('{32'hC, 64'h1F1E_1D1C, 8'h0F});
    exp_ov.push_back('{32'h0,  64'h0302_0100, 8'h0F});
    exp_ov.push_back('{32'h4,  64'h0706_0504, 8'h0F});
    exp_ov.push_back('{32'h8,  64'h0B0A_0908, 8'h0F});
    exp_ov.push_back('{32'h10, 64'h1312_1110, 8'h0F});
    exp_ov.push_back('{32'h14, 64'h1716_1514, 8'h0F});

    reset = 1'b1; rst_ov = 1'b1; ram_busy = 1'b1; reload = 1'b0;
    flash_dout = 8'h00; flash_strb = 1'b0; mem_ready = 1'b1; ready_ov = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_flash_start", 64'(fs32), 64'd0);
    check("rst_mem_valid",   64'(mv32), 64'd0);
    check("rst_mem_wstrb",   64'(ws32), 64'd0);
    check("rst_busy",        64'(busy32), 64'd0);
    check("rst_done",        64'(done32), 64'd0);
    check("rst_checksum",    64'(cs32), 64'd0);
    check("rst_error",       64'(err32), 64'd0);

    // RAM gating: no start while ram_busy is high
    reset = 1'b0;
    bad_start = 1'b0; bad_busy = 1'b0;
    repeat (50) begin
      tick();
      if (fs32) bad_start = 1'b1;
      if (!busy32) bad_busy = 1'b1;
    end
    check("gate_no_start", 64'(bad_start), 64'd0);
    check("gate_busy", 64'(bad_busy), 64'd0);
    ram_busy = 1'b0;
    tick();
    check("gate_start_pulse", 64'(fs32), 64'd1);
    tick();
    check("gate_start_one_cycle", 64'(fs32), 64'd0);

    // Basic copy: bytes 0x00..0x0F one every 8 cycles, ready held high
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      if (i == 3) begin
        check("lat_t1_valid", 64'(mv32), 64'd0);
        check("cs_after_byte3", 64'(cs32), 64'd6);
      end
      tick();
      if (i == 3) check("lat_t2_valid", 64'(mv32), 64'd1);
      if (i == 15) check("done_before_ack", 64'(done32), 64'd0);
      tick();
      if (i == 15) begin
        check("done_after_ack", 64'(done32), 64'd1);
        check("busy_after_ack", 64'(busy32), 64'd0);
      end
      repeat (5) tick();
    end
    check_writes("basic", q32, exp_basic);
    check("basic_checksum", 64'(cs32), 64'h78);
    check("basic_error", 64'(err32), 64'd0);
    check_writes("wide", q64, exp_64);
    check("wide_checksum", 64'(cs64), 64'h78);
    check("wide_done", 64'(done64), 64'd1);

    // Reload from DONE
    q32.delete(); q64.delete();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_done_clr", 64'(done32), 64'd0);
    check("reload_cs_clr", 64'(cs32), 64'd0);
    check("reload_busy", 64'(busy32), 64'd1);
    tick();
    check("reload_start", 64'(fs32), 64'd1);
    tick();

    // Backpressure: stream with ready low, hold the stall for 20 cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(16 + i));
    check("bp_valid", 64'(mv32), 64'd1);
    a0 = ma32; w0 = wd32;
    bad_stall = 1'b0;
    repeat (20) begin
      tick();
      if (!mv32 || ma32 !== a0 || wd32 !== w0) bad_stall = 1'b1;
    end
    check("bp_stable", 64'(bad_stall), 64'd0);
    check("bp_head_addr", 64'(a0), 64'd0);
    check("bp_head_data", 64'(w0), 64'h1312_1110);
    mem_ready = 1'b1;
    repeat (4) tick();
    check("bp_throughput", 64'(q32.size()), 64'd4);
    c = 0;
    while (!(done32 && done64) && c < 50) begin tick(); c++; end
    check("bp_done", 64'(done32), 64'd1);
    check_writes("bp", q32, exp_bp);
    check("bp_checksum", 64'(cs32), 64'h178);
    check("bp_error", 64'(err32), 64'd0);

    // Reset in the middle of a stalled copy, then a full re-run
    q32.delete();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    tick();
    check("abort_start", 64'(fs32), 64'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
    tick();
    check("abort_pre_valid", 64'(mv32), 64'd1);
    reset = 1'b1;
    tick();
    check("abort_valid_drop", 64'(mv32), 64'd0);
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_cs", 64'(cs32), 64'd0);
    reset = 1'b0;
    mem_ready = 1'b1;
    c = 0;
    while (!fs32 && c < 10) begin tick(); c++; end
    check("rerun_start", 64'(fs32), 64'd1);
    tick();
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    c = 0;
    while (!done32 && c < 50) begin tick(); c++; end
    check("rerun_done", 64'(done32), 64'd1);
    check("rerun_checksum", 64'(cs32), 64'h78);
    check_writes("rerun", q32, exp_basic);

    // Overflow on the 2-deep instance; other instances sit in DONE
    rst_ov = 1'b0;
    c = 0;
    while (!fs_ov && c < 10) begin tick(); c++; end
    check("ov_start", 64'(fs_ov), 64'd1);
    tick();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
      if (i == 11) check("ov_no_err_yet", 64'(err_ov), 64'd0);
      if (i == 15) check("ov_err_set", 64'(err_ov), 64'd1);
    end
    for (int i = 16; i < 19; i++) send_byte(8'(i));
    // Word 4 completes while full, on the edge that also pops
    ready_ov = 1'b1;
    for (int i = 19; i < 24; i++) send_byte(8'(i));
    c = 0;
    while (!done_ov && c < 50) begin tick(); c++; end
    check("ov_done", 64'(done_ov), 64'd1);
    check("ov_checksum", 64'(cs_ov), 64'h114);
    check("ov_error_sticky", 64'(err_ov), 64'd1);
    check_writes("ov", qov, exp_ov);
    check("ignored_strobes_cs", 64'(cs32), 64'h78);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
